gemm_tile_sequencer: RTL and testbench

- Top-level sequencing FSM directly upstream of systolic_array_controller.
- Runs one output-stationary GEMM tile per start pulse.
- Latches the top/left SRAM read windows and drives the 4-bit ctrl state IDLE→STEADY→FLUSH→DRAIN→IDLE.
- Watches the datapath down-valid bus to detect drain completion, then reports done or error to the host/testbench.

---
 rtl/gemm_pkg.sv | 23 ++
 rtl/seq_down_counter.sv | 36 +++
 rtl/gemm_tile_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared GEMM sequencing definitions: ctrl state codes (also decoded by
// systolic_array_controller) and a window-length helper.
package gemm_pkg;

  localparam int CTRL_WIDTH = 4;

  localparam logic [CTRL_WIDTH-1:0] IDLE   = 4'd0;
  localparam logic [CTRL_WIDTH-1:0] STEADY = 4'd1;
  localparam logic [CTRL_WIDTH-1:0] FLUSH  = 4'd2;
  localparam logic [CTRL_WIDTH-1:0] DRAIN  = 4'd3;

  typedef enum logic [CTRL_WIDTH-1:0] {
    ST_IDLE   = IDLE,
    ST_STEADY = STEADY,
    ST_FLUSH  = FLUSH,
    ST_DRAIN  = DRAIN
  } seq_state_e;

  function automatic int unsigned max_len(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with enable and zero flag; holds at zero.
module seq_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Per-tile IDLE->STEADY->FLUSH->DRAIN sequencer ahead of systolic_array_controller.
// Optional cycle counter on o_perf_cycles when GEMM_SEQ_PERF_CNT_EN is defined.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int NUM_ROW              = 8,
  parameter int NUM_COL              = 8,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int FLUSH_CYCLES         = NUM_ROW + NUM_COL,
  parameter int DRAIN_TIMEOUT        = 4 * NUM_ROW
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_end_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_end_addr,
  input  logic [NUM_COL-1:0]              i_valid_down,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_end_addr,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_err,
  output logic [31:0]                     o_perf_cycles
);

  localparam int AW      = LOG2_SRAM_BANK_DEPTH;
  localparam int LEN_W   = LOG2_SRAM_BANK_DEPTH + 1;
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam int BEAT_W  = $clog2(NUM_ROW + 1);
  localparam int TMO_W   = $clog2(DRAIN_TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     top_start_q, top_start_d, top_end_q, top_end_d;
  logic [AW-1:0]     left_start_q, left_start_d, left_end_q, left_end_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              done_q, done_d, err_q, err_d;

  logic [LEN_W-1:0]   top_len, left_len, steady_load_val, steady_cnt;
  logic [FLUSH_W-1:0] unused_flush_cnt;
  logic               steady_load, steady_en, flush_load, flush_en, flush_zero;
  logic               unused_steady_zero, bad_window, start_accept, valid_beat;
  logic               unused_valid;

  assign top_len         = {1'b0, i_top_end_addr} - {1'b0, i_top_start_addr};
  assign left_len        = {1'b0, i_left_end_addr} - {1'b0, i_left_start_addr};
  assign bad_window      = (i_top_end_addr <= i_top_start_addr) ||
                           (i_left_end_addr <= i_left_start_addr);
  assign steady_load_val = LEN_W'(max_len(32'(top_len), 32'(left_len)));
  assign start_accept    = (state_q == ST_IDLE) && i_start && !bad_window;
  assign valid_beat      = i_valid_down[NUM_COL-1];
  // Only the last column's valid marks a completed output row.
  assign unused_valid    = ^i_valid_down[NUM_COL-2:0];

  seq_down_counter #(.WIDTH(LEN_W)) u_steady_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (steady_load),
    .en       (steady_en),
    .load_val (steady_load_val),
    .count    (steady_cnt),
    .zero     (unused_steady_zero)
  );

  seq_down_counter #(.WIDTH(FLUSH_W)) u_flush_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (flush_load),
    .en       (flush_en),
    .load_val (FLUSH_W'(FLUSH_CYCLES - 1)),
    .count    (unused_flush_cnt),
    .zero     (flush_zero)
  );

  always_comb begin
    state_d      = state_q;
    top_start_d  = top_start_q;
    top_end_d    = top_end_q;
    left_start_d = left_start_q;
    left_end_d   = left_end_q;
    beat_d       = beat_q;
    tmo_d        = tmo_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    steady_load  = 1'b0;
    steady_en    = 1'b0;
    flush_load   = 1'b0;
    flush_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && bad_window) begin
          err_d = 1'b1;
        end else if (start_accept) begin
          top_start_d  = i_top_start_addr;
          top_end_d    = i_top_end_addr;
          left_start_d = i_left_start_addr;
          left_end_d   = i_left_end_addr;
          steady_load  = 1'b1;
          state_d      = ST_STEADY;
        end
      end
      ST_STEADY: begin
        steady_en = 1'b1;
        if (steady_cnt == LEN_W'(1)) begin
          flush_load = 1'b1;
          state_d    = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush_en = 1'b1;
        if (flush_zero) begin
          beat_d  = '0;
          tmo_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        tmo_d = tmo_q + 1'b1;
        if (valid_beat && (beat_q != BEAT_W'(NUM_ROW))) begin
          beat_d = beat_q + 1'b1;
        end
        // Completion waits one cycle after the last beat so the controller can drop its write enable.
        if (beat_q == BEAT_W'(NUM_ROW)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      top_start_q  <= '0;
      top_end_q    <= '0;
      left_start_q <= '0;
      left_end_q   <= '0;
      beat_q       <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      top_start_q  <= top_start_d;
      top_end_q    <= top_end_d;
      left_start_q <= left_start_d;
      left_end_q   <= left_end_d;
      beat_q       <= beat_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

`ifdef GEMM_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // The accepting cycle counts as the tile's first cycle.
  always_comb begin
    perf_d = perf_q;
    if (start_accept) begin
      perf_d = 32'd1;
    end else if ((state_q != ST_IDLE) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign o_perf_cycles = perf_q;
`else
  assign o_perf_cycles = '0;
`endif

  assign o_ctrl_state         = state_q;
  assign o_busy               = (state_q != ST_IDLE);
  assign o_done               = done_q;
  assign o_err                = err_q;
  assign o_top_rd_start_addr  = top_start_q;
  assign o_top_rd_end_addr    = top_end_q;
  assign o_left_rd_start_addr = left_start_q;
  assign o_left_rd_end_addr   = left_end_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Randomised self-checking bench for gemm_tile_sequencer against a tile-level timing model.
module tb_gemm_tile_sequencer;

  localparam int AW    = 10;
  localparam int NR    = 8;
  localparam int NC    = 8;
  localparam int FLUSH = NR + NC;
  localparam int TMO   = 4 * NR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_top_start_addr = '0, i_top_end_addr = '0;
  logic [AW-1:0] i_left_start_addr = '0, i_left_end_addr = '0;
  logic [NC-1:0] i_valid_down = '0;
  logic [3:0]    o_ctrl_state;
  logic [AW-1:0] o_top_rd_start_addr, o_top_rd_end_addr;
  logic [AW-1:0] o_left_rd_start_addr, o_left_rd_end_addr;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_perf_cycles;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] expTs = '0, expTe = '0, expLs = '0, expLe = '0;

  gemm_tile_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (i_start),
    .i_top_start_addr     (i_top_start_addr),
    .i_top_end_addr       (i_top_end_addr),
    .i_left_start_addr    (i_left_start_addr),
    .i_left_end_addr      (i_left_end_addr),
    .i_valid_down         (i_valid_down),
    .o_ctrl_state         (o_ctrl_state),
    .o_top_rd_start_addr  (o_top_rd_start_addr),
    .o_top_rd_end_addr    (o_top_rd_end_addr),
    .o_left_rd_start_addr (o_left_rd_start_addr),
    .o_left_rd_end_addr   (o_left_rd_end_addr),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .o_err                (o_err),
    .o_perf_cycles        (o_perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAddrs(input string tag);
    checkOutput({tag, "_top_start"}, 32'(o_top_rd_start_addr), 32'(expTs));
    checkOutput({tag, "_top_end"}, 32'(o_top_rd_end_addr), 32'(expTe));
    checkOutput({tag, "_left_start"}, 32'(o_left_rd_start_addr), 32'(expLs));
    checkOutput({tag, "_left_end"}, 32'(o_left_rd_end_addr), 32'(expLe));
  endtask

  task automatic checkIdle(input string tag, input bit expDone, input bit expErr);
    checkOutput({tag, "_ctrl"}, 32'(o_ctrl_state), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(o_done), 32'(expDone));
    checkOutput({tag, "_err"}, 32'(o_err), 32'(expErr));
    checkAddrs(tag);
  endtask

  task automatic checkPerf(input string tag, input int exp);
`ifdef GEMM_SEQ_PERF_CNT_EN
    checkOutput({tag, "_perf"}, o_perf_cycles, 32'(exp));
`else
    checkOutput({tag, "_perf"}, o_perf_cycles, 32'd0 & 32'(exp));
`endif
  endtask

  task automatic checkBusy(input string tag, input int code);
    checkOutput({tag, "_ctrl"}, 32'(o_ctrl_state), 32'(code));
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd1);
    checkOutput({tag, "_done_err"}, 32'({o_done, o_err}), 32'd0);
    checkAddrs(tag);
  endtask

  // mode 0: beat every DRAIN cycle, 1: random beats, 2: only three beats.
  // abortAt > 0 pulls reset during that DRAIN cycle.
  task automatic applyStimulus(input int ts, input int te, input int ls, input int le,
                               input int mode, input int abortAt);
    int  len, beats, b8, drainLen;
    bit  v, expDone;
    len = ((te - ts) > (le - ls)) ? (te - ts) : (le - ls);
    i_top_start_addr  = AW'(ts);
    i_top_end_addr    = AW'(te);
    i_left_start_addr = AW'(ls);
    i_left_end_addr   = AW'(le);
    i_start = 1'b1;
    step();
    expTs = AW'(ts); expTe = AW'(te); expLs = AW'(ls); expLe = AW'(le);
    for (int c = 0; c < len + FLUSH; c++) begin
      checkBusy((c < len) ? "steady" : "flush", (c < len) ? 1 : 2);
      i_start           = ($urandom_range(0, 3) == 0);
      i_top_start_addr  = AW'($urandom);
      i_top_end_addr    = AW'($urandom);
      i_left_start_addr = AW'($urandom);
      i_left_end_addr   = AW'($urandom);
      i_valid_down      = NC'($urandom);
      step();
    end
    i_start = 1'b0;
    beats = 0;
    b8 = 0;
    drainLen = TMO;
    for (int c = 1; c <= TMO; c++) begin
      checkBusy("drain", 3);
      if (c == abortAt) begin
        rst_n = 1'b0;
        #1;
        expTs = '0; expTe = '0; expLs = '0; expLe = '0;
        checkIdle("reset_async", 1'b0, 1'b0);
        checkPerf("reset_async", 0);
        step();
        step();
        checkIdle("reset_held", 1'b0, 1'b0);
        rst_n = 1'b1;
        i_valid_down = '0;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 9) < 6);
        default: v = (beats < 3);
      endcase
      i_valid_down = {v, 7'($urandom)};
      if (v) beats++;
      if (beats == NR && b8 == 0) b8 = c;
      step();
      if (b8 != 0 && c == b8 + 1) begin
        drainLen = c;
        break;
      end
    end
    i_valid_down = '0;
    expDone = (b8 != 0) && (b8 + 1 <= TMO);
    checkIdle(expDone ? "tile_done" : "tile_timeout", expDone, !expDone);
    checkPerf("tile", 1 + len + FLUSH + drainLen);
  endtask

  task automatic badWindow(input int ts, input int te, input int ls, input int le);
    i_top_start_addr  = AW'(ts);
    i_top_end_addr    = AW'(te);
    i_left_start_addr = AW'(ls);
    i_left_end_addr   = AW'(le);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    checkIdle("bad_window", 1'b0, 1'b1);
    step();
    checkIdle("bad_window_after", 1'b0, 1'b0);
  endtask

  initial begin
    int ts, ls, tl, ll;
    rst_n = 1'b0;
    step();
    step();
    checkIdle("reset", 1'b0, 1'b0);
    checkPerf("reset", 0);
    rst_n = 1'b1;
    step();
    checkIdle("post_reset", 1'b0, 1'b0);

    applyStimulus(0, 8, 0, 8, 0, 0);
    step();
    checkIdle("done_drop", 1'b0, 1'b0);
    applyStimulus(0, 5, 4, 16, 0, 0);
    step();
    badWindow(8, 8, 0, 8);
    badWindow(0, 8, 9, 3);
    applyStimulus(100, 101, 200, 201, 1, 0);
    step();
    applyStimulus(0, 8, 0, 8, 2, 0);
    step();
    checkIdle("err_drop", 1'b0, 1'b0);

    applyStimulus(10, 20, 30, 35, 0, 0);
    applyStimulus(40, 48, 50, 52, 1, 0);
    step();
    applyStimulus(0, 8, 0, 8, 0, 4);
    step();
    applyStimulus(0, 8, 0, 8, 0, 0);
    step();

    for (int n = 0; n < 10; n++) begin
      ts = $urandom_range(0, 1000);
      ls = $urandom_range(0, 1000);
      tl = $urandom_range(1, 20);
      ll = $urandom_range(1, 20);
      if ($urandom_range(0, 4) == 0) begin
        badWindow(ts, ts - $urandom_range(0, 3), ls, ls + ll);
      end else begin
        applyStimulus(ts, ts + tl, ls, ls + ll, $urandom_range(0, 2), 0);
        if ($urandom_range(0, 1) == 0) step();
      end
    end
    step();
    checkIdle("final", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
